// File: rtl/ec1_pkg.sv
// ec1_pkg: shared opcode and state encodings for the EC-1 control unit
// Optional feature macro: EC1_STEP_EN (adds ST_STEPWAIT usage in the top)
package ec1_pkg;
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_IN   = 3'b011;
   localparam logic [2:0] OP_OUT  = 3'b100;
   localparam logic [2:0] OP_DEC  = 3'b101;
   localparam logic [2:0] OP_JNZ  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;
   typedef enum logic [2:0] {
      ST_START    = 3'd0,
      ST_FETCH    = 3'd1,
      ST_DECODE   = 3'd2,
      ST_EXEC     = 3'd3,
      ST_INWAIT   = 3'd4,
      ST_JWAIT    = 3'd5,
      ST_HALT     = 3'd6,
      ST_STEPWAIT = 3'd7
   } state_e;
   typedef struct packed {
      logic is_in;
      logic is_out;
      logic is_dec;
      logic is_jnz;
      logic is_halt;
   } opc_t;
endpackage

// File: rtl/ec1_opcode_decode.sv
// ec1_opcode_decode: combinational IR[7:5] to one-hot instruction class
// Ports: opc_i (opcode in), dec_o (one-hot {is_in,is_out,is_dec,is_jnz,is_halt})
module ec1_opcode_decode
   import ec1_pkg::*;
#(
   parameter int OPC_W = 3
) (
   input  logic [OPC_W-1:0] opc_i,
   output opc_t             dec_o
);
   assign dec_o = '{
      is_in:   opc_i == OPC_W'(OP_IN),
      is_out:  opc_i == OPC_W'(OP_OUT),
      is_dec:  opc_i == OPC_W'(OP_DEC),
      is_jnz:  opc_i == OPC_W'(OP_JNZ),
      is_halt: opc_i == OPC_W'(OP_HALT)
   };
endmodule

// File: rtl/ec1_control_unit.sv
// ec1_control_unit: fetch/decode/execute sequencer for the EC-1 accumulator CPU
// Ports: Clk, Reset (async active-low), IR75 opcode, Aneq0 flag, Enter handshake,
//        datapath strobes INmux/Aload/IRload/PCload/JNZmux, InReq, OutValid, Halt,
//        State (debug). Macro EC1_STEP_EN adds the Step input and STEPWAIT state.
module ec1_control_unit
   import ec1_pkg::*;
#(
   parameter int OPC_W = 3,
   parameter int ST_W  = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [OPC_W-1:0] IR75,
   input  logic             Aneq0,
   input  logic             Enter,
`ifdef EC1_STEP_EN
   input  logic             Step,
`endif
   output logic             INmux,
   output logic             Aload,
   output logic             IRload,
   output logic             PCload,
   output logic             JNZmux,
   output logic             InReq,
   output logic             OutValid,
   output logic             Halt,
   output logic [ST_W-1:0]  State
);
   state_e state_q, state_d, fetch_nx;
   opc_t   dec;
   logic   fetch_q, dec_a_q, jnz_q, inwait_q, outv_q, halt_q;
   ec1_opcode_decode #(.OPC_W(OPC_W)) u_dec (.opc_i(IR75), .dec_o(dec));
   // Every path back into FETCH passes through this gate so single-stepping can park the FSM
`ifdef EC1_STEP_EN
   assign fetch_nx = Step ? ST_FETCH : ST_STEPWAIT;
`else
   assign fetch_nx = ST_FETCH;
`endif
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START:  state_d = fetch_nx;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = dec.is_in ? ST_INWAIT : dec.is_halt ? ST_HALT : ST_EXEC;
         ST_EXEC:   state_d = (dec.is_jnz && Aneq0) ? ST_JWAIT : fetch_nx;
         ST_INWAIT: state_d = Enter ? fetch_nx : ST_INWAIT;
         ST_JWAIT:  state_d = fetch_nx;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = fetch_nx;
      endcase
   end
   // Moore strobes are registered from the next state; IR is stable from DECODE through EXEC
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_START;
         fetch_q  <= 1'b0;
         dec_a_q  <= 1'b0;
         jnz_q    <= 1'b0;
         inwait_q <= 1'b0;
         outv_q   <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         fetch_q  <= state_d == ST_FETCH;
         dec_a_q  <= state_d == ST_EXEC && dec.is_dec;
         jnz_q    <= state_d == ST_EXEC && dec.is_jnz;
         inwait_q <= state_d == ST_INWAIT;
         outv_q   <= state_d == ST_EXEC && dec.is_out;
         halt_q   <= state_d == ST_HALT;
      end
   end
   // Only the JNZ load and the IN load follow their inputs combinationally
   assign INmux    = inwait_q;
   assign Aload    = dec_a_q | (inwait_q & Enter);
   assign IRload   = fetch_q;
   assign PCload   = fetch_q | (jnz_q & Aneq0);
   assign JNZmux   = jnz_q;
   assign InReq    = inwait_q;
   assign OutValid = outv_q;
   assign Halt     = halt_q;
   assign State    = ST_W'(state_q);
endmodule
